// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO state encoding and width helpers
package fifo_pkg;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH register array, sync write, async read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 10
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]         o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // storage is never reset; contents are don't-care until written
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with flags, errors and optional FWFT
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 10,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

  fifo_state_t r_state, w_state_next;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [DATA_W-1:0] r_dout, w_rdata;
  logic r_dout_valid, r_ovf, r_udf, w_wr_acc, w_rd_acc;

  // explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == LAST ? '0 : p + PTR_W'(1);
  endfunction

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // acceptance from start-of-cycle state; a pop frees room for a write when full
  always_comb begin
    w_rd_acc = rd_en & (r_state != EMPTY);
    w_wr_acc = wr_en & ((r_state != FULL) | w_rd_acc);
    w_count_next = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= EMPTY;
    else r_state <= w_state_next;

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   w_state_next = w_wr_acc ? PARTIAL : EMPTY;
      PARTIAL: w_state_next = w_count_next == FULL_CNT ? FULL : w_count_next == '0 ? EMPTY : PARTIAL;
      FULL:    w_state_next = (w_rd_acc & ~w_wr_acc) ? PARTIAL : FULL;
      default: w_state_next = EMPTY;
    endcase
  end

  // pointers, occupancy, error pulses and registered read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_dout <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_acc ? inc(r_wr_ptr) : r_wr_ptr;
      r_rd_ptr <= w_rd_acc ? inc(r_rd_ptr) : r_rd_ptr;
      r_count <= w_count_next;
      r_ovf <= wr_en & ~w_wr_acc;
      r_udf <= rd_en & ~w_rd_acc;
      r_dout <= (FWFT == 0 && w_rd_acc) ? w_rdata : r_dout;
      r_dout_valid <= (FWFT == 0) & w_rd_acc;
    end

  // outputs purely from registered state; FWFT exposes the head word directly
  always_comb begin
    full = r_state == FULL;
    empty = r_state == EMPTY;
    almost_full = r_count >= AF_CNT;
    almost_empty = r_count <= AE_CNT;
    count = r_count;
    overflow = r_ovf;
    underflow = r_udf;
    dout = FWFT != 0 ? (empty ? '0 : w_rdata) : r_dout;
    dout_valid = FWFT != 0 ? ~empty : r_dout_valid;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed checks of both read modes against a queue model
module tb_sync_fifo_param;
  localparam int DEPTH = 10;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout, f_dout;
  logic dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] count, f_count;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // one clock of stimulus to both instances; model updated with FIFO semantics
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic racc, wacc;
    wr_en = w; din = d; rd_en = r;
    racc = r && q.size() != 0;
    wacc = w && (q.size() != DEPTH || racc);
    m_ovf = w && !wacc;
    m_udf = r && !racc;
    m_dv = racc;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {dout, dout_valid, count, full, empty, almost_full, almost_empty, overflow, underflow};
    total++; if (got !== {8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL reset_outputs got=%h want=%h", got, {8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}); end
    total++; if ({f_dv, f_empty, f_count} !== {1'b0, 1'b1, 4'd0}) begin bad++; $display("FAIL reset_fwft got=%b%b%h want=010", f_dv, f_empty, f_count); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) cyc(1'b1, exp[i], 1'b0);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      total++; if ({dout, dout_valid, count} !== {exp[i], 1'b1, 4'(2 - i)}) begin bad++; $display("FAIL basic_read%0d got=%h/%b/%0d want=%h/1/%0d", i, dout, dout_valid, count, exp[i], 2 - i); end
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++; if ({dout, dout_valid, empty} !== {8'h33, 1'b0, 1'b1}) begin bad++; $display("FAIL basic_idle got=%h/%b/%b want=33/0/1", dout, dout_valid, empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      total++; if ({almost_full, full, count} !== {i >= 8, i == DEPTH, 4'(i)}) begin bad++; $display("FAIL fill%0d af/full/count got=%b/%b/%0d want=%b/%b/%0d", i, almost_full, full, count, i >= 8, i == DEPTH, i); end
    end
    cyc(1'b1, 8'hFF, 1'b0);
    total++; if ({overflow, count, full} !== {1'b1, 4'd10, 1'b1}) begin bad++; $display("FAIL overflow_pulse got=%b/%0d/%b want=1/10/1", overflow, count, full); end
    cyc(1'b0, 8'h00, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b want=0", overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      total++; if (dout !== 8'(i) || dout_valid !== 1'b1) begin bad++; $display("FAIL drain%0d got=%h/%b want=%h/1", i, dout, dout_valid, 8'(i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_full_rw_wrap();
    logic [7:0] exp [10] = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 8'hA0 + 8'(k), 1'b1);
      total++; if ({dout, count, full, overflow} !== {8'(k + 1), 4'd10, 1'b1, 1'b0}) begin bad++; $display("FAIL full_rw%0d got=%h/%0d/%b/%b want=%h/10/1/0", k, dout, count, full, overflow, 8'(k + 1)); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      total++; if (dout !== exp[i]) begin bad++; $display("FAIL wrap_read%0d got=%h want=%h", i, dout, exp[i]); end
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 8'h00, 1'b1);
    total++; if ({underflow, count} !== {1'b1, 4'd0}) begin bad++; $display("FAIL underflow_alone got=%b/%0d want=1/0", underflow, count); end
    cyc(1'b1, 8'h5A, 1'b1);
    total++; if ({underflow, count, empty, dout_valid} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL underflow_wr got=%b/%0d/%b/%b want=1/1/0/0", underflow, count, empty, dout_valid); end
    cyc(1'b0, 8'h00, 1'b1);
    total++; if ({dout, underflow} !== {8'h5A, 1'b0}) begin bad++; $display("FAIL underflow_read got=%h/%b want=5a/0", dout, underflow); end
  endtask

  task automatic test_fwft();
    cyc(1'b1, 8'hC3, 1'b0);
    total++; if ({f_dout, f_dv} !== {8'hC3, 1'b1}) begin bad++; $display("FAIL fwft_first got=%h/%b want=c3/1", f_dout, f_dv); end
    cyc(1'b0, 8'h00, 1'b0);
    total++; if ({f_dout, f_dv} !== {8'hC3, 1'b1}) begin bad++; $display("FAIL fwft_hold got=%h/%b want=c3/1", f_dout, f_dv); end
    cyc(1'b0, 8'h00, 1'b1);
    total++; if ({f_empty, f_dv} !== {1'b1, 1'b0}) begin bad++; $display("FAIL fwft_pop got=%b/%b want=1/0", f_empty, f_dv); end
    cyc(1'b1, 8'hD1, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0);
    total++; if (f_dout !== 8'hD1) begin bad++; $display("FAIL fwft_head got=%h want=d1", f_dout); end
    cyc(1'b0, 8'h00, 1'b1);
    total++; if ({f_dout, f_dv} !== {8'hD2, 1'b1}) begin bad++; $display("FAIL fwft_next got=%h/%b want=d2/1", f_dout, f_dv); end
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0);
    total++; if (count !== 4'd4) begin bad++; $display("FAIL pre_reset_count got=%0d want=4", count); end
    #2 rst = 1'b1;
    #1;
    total++; if ({count, empty, dout, dout_valid, f_count, f_empty} !== {4'd0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b1}) begin bad++; $display("FAIL async_reset got=%0d/%b/%h/%b/%0d/%b want=0/1/00/0/0/1", count, empty, dout, dout_valid, f_count, f_empty); end
    #1 rst = 1'b0;
    model_reset();
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    total++; if ({dout, dout_valid, empty} !== {8'h77, 1'b1, 1'b1}) begin bad++; $display("FAIL post_reset got=%h/%b/%b want=77/1/1", dout, dout_valid, empty); end
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = (i / 100) % 3 == 0 ? 75 : (i / 100) % 3 == 1 ? 50 : 25;
      cyc(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < 100 - wp));
      got = {dout, dout_valid, count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = {m_dout, m_dv, 4'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() >= 8, q.size() <= 2, m_ovf, m_udf};
      total++; if (got !== exp) begin bad++; $display("FAIL rand_dut cyc=%0d got=%h want=%h", i, got, exp); end
      total++; if ({f_dv, f_count, f_ovf, f_udf} !== {q.size() != 0, 4'(q.size()), m_ovf, m_udf}) begin bad++; $display("FAIL rand_fwft_flags cyc=%0d got=%b/%0d/%b/%b want=%b/%0d/%b/%b", i, f_dv, f_count, f_ovf, f_udf, q.size() != 0, q.size(), m_ovf, m_udf); end
      if (q.size() != 0) begin
        total++; if (f_dout !== q[0]) begin bad++; $display("FAIL rand_fwft_head cyc=%0d got=%h want=%h", i, f_dout, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw_wrap();
    test_underflow();
    test_fwft();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 10-entry byte FIFO. Generalised data width and depth, with non-power-of-two depths supported. Adds full/empty/almost flags, an occupancy count, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. Used as the standard buffering element between producer/consumer blocks in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, need not be a power of two)
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request / pop
dout  out  DATA_W  read data
dout_valid  out  1  dout holds valid data (meaning depends on FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CNT_W  occupancy, CNT_W = clog2(DEPTH+1)
overflow  out  1  one-cycle pulse: write rejected because full
underflow  out  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (async, any time, including mid-transfer): wr_ptr=0, rd_ptr=0, count=0, state=EMPTY, dout=0, dout_valid=0, overflow=underflow=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). Storage contents are not reset; they are don't-care.
- Pointers range 0..DEPTH-1. Increment wraps DEPTH-1 -> 0 explicitly; no reliance on binary rollover.
- State machine: EMPTY, PARTIAL, FULL. Flags come from registered state and count; no combinational path from wr_en/rd_en to flags.
- All decisions use state at the start of the cycle:
  - wr_acc = wr_en & (!full | rd_acc)
  - rd_acc = rd_en & !empty
- Full with wr_en and rd_en: both accepted; count stays DEPTH.
- Empty with wr_en and rd_en: write accepted, read rejected, underflow pulses; no write-through.
- count_next = count + wr_acc - rd_acc.
- Transitions:
  - EMPTY->PARTIAL on wr_acc (or ->FULL if DEPTH==1 is disallowed; DEPTH>=2).
  - PARTIAL->FULL when count_next==DEPTH; PARTIAL->EMPTY when count_next==0; otherwise stay.
  - FULL->PARTIAL on rd_acc without wr_acc.
- overflow = registered (wr_en & !wr_acc). underflow = registered (rd_en & !rd_acc). Both high exactly one cycle after the offending request; the FIFO state is unchanged by the rejected operation.
- FWFT=0:
  - On rd_acc, dout <= mem[rd_ptr] at that edge; data is visible in the following cycle.
  - dout_valid pulses high in that cycle only.
  - dout holds its last value otherwise.
- FWFT=1:
  - dout = mem[rd_ptr] whenever !empty; rd_en pops the head.
  - dout_valid = !empty.
  - First written word appears on dout one cycle after its write edge.
  - dout is don't-care while empty.
- Data order is strict FIFO across pointer wrap.
- No data corruption on simultaneous read and write to the same index; this only occurs when count is 0 (read rejected) or DEPTH (read uses old word).

Decomposition:
- Shared package fifo_pkg:
  - enum fifo_state_t {EMPTY, PARTIAL, FULL}
  - clog2-based width helper for CNT_W and pointer width
  - reused by future async/multichannel FIFO variants
- One sub-module: fifo_mem.
  - Parametrised DATA_W × DEPTH register array.
  - Synchronous write port (we, waddr, wdata) and combinational read port (raddr -> rdata).
  - Top level holds pointers, count, state machine, flags and the dout register.

Test Plan:
- Reset, then write 0x11,0x22,0x33, then three reads (FWFT=0) -> dout 0x11,0x22,0x33 on consecutive cycles after each rd edge, dout_valid pulses, count 3->0, empty=1 at end.
- Write 10 words 0x01..0x0A (DEPTH=10) -> full=1, count=10, almost_full from count=8. An 11th write 0xFF -> overflow pulses one cycle; a subsequent drain reads 0x01..0x0A with no 0xFF.
- Fill to 10, then assert wr_en+rd_en for 5 cycles writing 0xA0..0xA4 -> count stays 10, full stays 1. Reads return 0x01..0x05, then later 0x06..0x0A, then 0xA0..0xA4 (wrap check).
- On empty FIFO, assert rd_en alone -> underflow pulse, count 0. Then wr_en+rd_en with din 0x5A -> write accepted, underflow pulse, count=1, next read returns 0x5A.
- FWFT=1: write 0xC3 -> next cycle dout=0xC3, dout_valid=1 without rd_en. rd_en -> empty=1, dout_valid=0.
- Write 4 words, assert rst mid-burst for one cycle asynchronously -> count=0, empty=1, dout=0 immediately. A following write/read of 0x77 returns 0x77.
